// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Shared state codes and default timing constants for the
//            stopwatch control block.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_LAP   = 3'd3,
      ST_DONE  = 3'd4
   } sw_state_t;

   localparam int c_DEF_TICK_DIV        = 5000000;
   localparam int c_DEF_DEBOUNCE_CYCLES = 500000;

   // Reduced-scale timing for simulation
   localparam int c_BENCH_TICK_DIV        = 5;
   localparam int c_BENCH_DEBOUNCE_CYCLES = 4;

   function automatic logic is_counting(input sw_state_t st);
      return (st == ST_RUN) || (st == ST_LAP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Brief    : Two-flop synchronizer, debounce counter and one-cycle press pulse
//            on the debounced rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]         r_sync;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_level;
   logic               r_level_q;
   logic               r_press;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync    <= 2'b00;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_level_q <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], btn_raw};
         // Any sample agreeing with the current level restarts the run
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_CNT_LAST) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_level_q <= r_level;
         r_press   <= r_level & ~r_level_q;
      end
   end

   assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Brief    : Start/pause/lap/clear sequencing, 0.1 s tick prescaler and button
//            conditioning. Optional auto-stop: STOPWATCH_AUTO_STOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV        = c_DEF_TICK_DIV,
   parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_ss,
   input  logic       btn_lr,
   input  logic       at_max,
   output logic       tick,
   output logic       clear,
   output logic       freeze,
   output logic       running,
   output logic [2:0] state
);

   localparam int c_PS_W = $clog2(TICK_DIV);
   localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(TICK_DIV - 1);

   sw_state_t         r_state;
   sw_state_t         w_next;
   logic [c_PS_W-1:0] r_presc;
   logic              r_tick;
   logic              r_clear;
   logic              r_freeze;
   logic              r_running;
   logic              w_ss_press;
   logic              w_lr_press;
   logic              w_clear_req;
   logic              w_counting;
   logic              w_terminal;
   logic              w_auto_stop;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
      .clock   (clock),
      .reset   (reset),
      .btn_raw (btn_ss),
      .press   (w_ss_press)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
      .clock   (clock),
      .reset   (reset),
      .btn_raw (btn_lr),
      .press   (w_lr_press)
   );

   assign w_counting = is_counting(r_state);
   assign w_terminal = w_counting && (r_presc == c_PS_LAST);

`ifdef STOPWATCH_AUTO_STOP_EN
   assign w_auto_stop = w_terminal && at_max;
`else
   logic w_unused_at_max;
   assign w_unused_at_max = at_max;
   assign w_auto_stop     = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ss wins over lr when both arrive together
   always_comb begin
      w_next      = r_state;
      w_clear_req = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ss_press)      w_next = ST_RUN;
            else if (w_lr_press) w_clear_req = 1'b1;
         end
         ST_RUN: begin
            if (w_ss_press)      w_next = ST_PAUSE;
            else if (w_lr_press) w_next = ST_LAP;
         end
         ST_LAP: begin
            if (w_ss_press)      w_next = ST_PAUSE;
            else if (w_lr_press) w_next = ST_RUN;
         end
         ST_PAUSE: begin
            if (w_ss_press) begin
               w_next = ST_RUN;
            end else if (w_lr_press) begin
               w_next      = ST_IDLE;
               w_clear_req = 1'b1;
            end
         end
         ST_DONE: begin
            if (w_lr_press) begin
               w_next      = ST_IDLE;
               w_clear_req = 1'b1;
            end
         end
         default: w_next = ST_IDLE;
      endcase
      if (w_auto_stop) begin
         w_next      = ST_DONE;
         w_clear_req = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_presc   <= '0;
         r_tick    <= 1'b0;
         r_clear   <= 1'b0;
         r_freeze  <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_clear   <= w_clear_req;
         r_tick    <= w_terminal & ~w_auto_stop & ~w_clear_req;
         r_running <= is_counting(w_next);
         r_freeze  <= (w_next == ST_LAP);
         // Prescaler holds outside RUN/LAP so a paused tenth resumes intact
         if (w_clear_req) begin
            r_presc <= '0;
         end else if (w_counting) begin
            r_presc <= w_terminal ? '0 : r_presc + 1'b1;
         end
      end
   end

   assign tick    = r_tick;
   assign clear   = r_clear;
   assign freeze  = r_freeze;
   assign running = r_running;
   assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Brief    : Directed self-checking bench for stopwatch_ctrl at reduced timing;
//            tick/clear timing is scoreboarded. Honours STOPWATCH_AUTO_STOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       btn_ss;
   logic       btn_lr;
   logic       at_max;
   logic       tick;
   logic       clear;
   logic       freeze;
   logic       running;
   logic [2:0] state;

   int cyc     = 0;
   int checks  = 0;
   int errors  = 0;
   int m_presc = 0;
   int tick_q[$];
   int clear_q[$];

   stopwatch_ctrl #(
      .TICK_DIV        (c_BENCH_TICK_DIV),
      .DEBOUNCE_CYCLES (c_BENCH_DEBOUNCE_CYCLES)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .btn_ss  (btn_ss),
      .btn_lr  (btn_lr),
      .at_max  (at_max),
      .tick    (tick),
      .clear   (clear),
      .freeze  (freeze),
      .running (running),
      .state   (state)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clock);
   endtask

   // which: 0 = ss, 1 = lr, 2 = both; transition lands 8 edges after the call
   task automatic press(input int which);
      if (which != 1) btn_ss = 1'b1;
      if (which != 0) btn_lr = 1'b1;
      repeat (10) @(negedge clock);
      btn_ss = 1'b0;
      btn_lr = 1'b0;
      repeat (8) @(negedge clock);
   endtask

   // Expected ticks for len counting edges following the edge that entered RUN
   function automatic void plan_run(input int entry, input int len);
      for (int i = 1; i <= len; i++) begin
         if (m_presc == c_BENCH_TICK_DIV - 1) begin
            tick_q.push_back(entry + i);
            m_presc = 0;
         end else begin
            m_presc++;
         end
      end
   endfunction

   always @(negedge clock) begin
      if (tick === 1'b1) begin
         if (tick_q.size() > 0) check("tick_cycle", cyc, tick_q.pop_front());
         else                   check("tick_unexpected", int'(tick), 0);
      end else if (tick_q.size() > 0 && tick_q[0] <= cyc) begin
         void'(tick_q.pop_front());
         check("tick_missing", int'(tick), 1);
      end
      if (clear === 1'b1) begin
         if (clear_q.size() > 0) check("clear_cycle", cyc, clear_q.pop_front());
         else                    check("clear_unexpected", int'(clear), 0);
      end else if (clear_q.size() > 0 && clear_q[0] <= cyc) begin
         void'(clear_q.pop_front());
         check("clear_missing", int'(clear), 1);
      end
   end

   initial begin
      reset  = 1'b1;
      btn_ss = 1'b0;
      btn_lr = 1'b0;
      at_max = 1'b0;
      wait_cyc(3);
      check("rst_state",   int'(state),   0);
      check("rst_running", int'(running), 0);
      check("rst_freeze",  int'(freeze),  0);
      check("rst_tick",    int'(tick),    0);
      check("rst_clear",   int'(clear),   0);
      reset = 1'b0;

      // Bounced start press: final rise at cyc 7, press at 14, RUN at 15
      wait_cyc(5);
      plan_run(15, 23);
      btn_ss = 1'b1;
      @(negedge clock); btn_ss = 1'b0;
      @(negedge clock); btn_ss = 1'b1;
      wait_cyc(14);
      check("ss_not_early", int'(state), 0);
      wait_cyc(15);
      check("ss_run_state",   int'(state),   1);
      check("ss_run_running", int'(running), 1);
      wait_cyc(17);
      btn_ss = 1'b0;

      // Stop with prescaler at 3 (edge 38), resume at 56: tick two edges later
      wait_cyc(30);
      press(0);
      check("pause_state",   int'(state),   2);
      check("pause_running", int'(running), 0);
      plan_run(56, 54);
      press(0);
      check("resume_state", int'(state), 1);
      press(1);
      check("lap_state",   int'(state),   3);
      check("lap_freeze",  int'(freeze),  1);
      check("lap_running", int'(running), 1);
      press(1);
      check("unlap_state",  int'(state),  1);
      check("unlap_freeze", int'(freeze), 0);
      press(2);
      check("both_state",  int'(state),  2);
      check("both_freeze", int'(freeze), 0);

      // PAUSE -> IDLE with clear, then clear from IDLE
      clear_q.push_back(128);
      m_presc = 0;
      press(1);
      check("pause_lr_state", int'(state), 0);
      clear_q.push_back(146);
      press(1);
      check("idle_lr_state", int'(state), 0);

      // Restart from zeroed prescaler, then reset mid-RUN at edge 181
      plan_run(164, 16);
      press(0);
      check("restart_state", int'(state), 1);
      wait_cyc(180);
      reset = 1'b1;
      wait_cyc(181);
      check("midrst_state",   int'(state),   0);
      check("midrst_running", int'(running), 0);
      check("midrst_freeze",  int'(freeze),  0);
      check("midrst_tick",    int'(tick),    0);
      check("midrst_clear",   int'(clear),   0);
      reset   = 1'b0;
      m_presc = 0;

      // at_max at the first terminal count (edge 198)
      wait_cyc(185);
      at_max = 1'b1;
`ifdef STOPWATCH_AUTO_STOP_EN
      plan_run(193, 4);
      press(0);
      check("done_state",   int'(state),   4);
      check("done_running", int'(running), 0);
      check("done_freeze",  int'(freeze),  0);
      at_max = 1'b0;
      press(0);
      check("done_ss_ignored", int'(state), 4);
      clear_q.push_back(229);
      press(1);
      check("done_lr_state", int'(state), 0);
`else
      plan_run(193, 20);
      press(0);
      check("atmax_ignored_state", int'(state), 1);
      wait_cyc(205);
      press(0);
      check("stop_on_terminal_state", int'(state), 2);
      at_max = 1'b0;
      clear_q.push_back(231);
      press(1);
      check("final_idle_state", int'(state), 0);
`endif

      wait_cyc(250);
      check("tick_q_drained",  tick_q.size(),  0);
      check("clear_q_drained", clear_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
